// File: rtl/i2s_pkg.sv
// Shared types and limits for the oversampling I2S frame receiver.
package i2s_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } rx_state_e;

   localparam int CNT_W    = 6;
   localparam int MAX_BITS = 32;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser for an asynchronous level, with single-cycle rise detect
// taken from the synchronised output and one further registered copy.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              level_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '0;
         level_prev_q <= 1'b0;
      end else begin
         sync_q       <= {sync_q[STAGES-2:0], d_i};
         level_prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~level_prev_q;

endmodule

// File: rtl/i2s_frame_rx.sv
// Standard-format I2S receiver oversampled in clk: deserialises MSB-first words
// into a 1-deep valid/ready buffer and flags short slots and overruns.
//   state | meaning
//   HUNT  | waiting for the first WS transition; bits ignored
//   RECV  | word-aligned; collecting bits of the current slot
module i2s_frame_rx
   import i2s_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i2s_sck,
   input  logic              i2s_ws,
   input  logic              i2s_sd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_right,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic              short_err
);

   localparam logic [DATA_W-1:0] MSB_BIT = DATA_W'(1) << (DATA_W - 1);

   logic                   sck_rise;
   logic [SYNC_STAGES-1:0] ws_sync_q;
   logic [SYNC_STAGES-1:0] sd_sync_q;
   logic                   ws_s;
   logic                   sd_s;

   rx_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]      shift_q, shift_d;
   logic                   ws_prev_q, ws_prev_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   right_q, right_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;
   logic                   short_q, short_d;

   logic                   ws_chg;
   logic [DATA_W-1:0]      bit_mask;
   logic [DATA_W-1:0]      word;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (i2s_sck),
      .rise_o (sck_rise)
   );

   // ws and sd get the same depth as sck so a rise samples them in step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws_sync_q <= '0;
         sd_sync_q <= '0;
      end else begin
         ws_sync_q <= {ws_sync_q[SYNC_STAGES-2:0], i2s_ws};
         sd_sync_q <= {sd_sync_q[SYNC_STAGES-2:0], i2s_sd};
      end
   end

   assign ws_s = ws_sync_q[SYNC_STAGES-1];
   assign sd_s = sd_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HUNT;
         cnt_q     <= '0;
         shift_q   <= '0;
         ws_prev_q <= 1'b0;
         data_q    <= '0;
         right_q   <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         short_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         ws_prev_q <= ws_prev_d;
         data_q    <= data_d;
         right_q   <= right_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         short_q   <= short_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      ws_prev_d = ws_prev_q;
      data_d    = data_q;
      right_d   = right_q;
      valid_d   = valid_q & ~out_ready;
      overrun_d = 1'b0;
      short_d   = 1'b0;

      ws_chg   = ws_s ^ ws_prev_q;
      // Bits past DATA_W contribute nothing: the word is truncated, not rounded.
      bit_mask = (cnt_q < CNT_W'(DATA_W)) ? (MSB_BIT >> cnt_q) : '0;
      word     = shift_q | (sd_s ? bit_mask : '0);

      if (sck_rise) begin
         ws_prev_d = ws_s;
         case (state_q)
            HUNT: begin
               if (ws_chg) begin
                  state_d = RECV;
                  cnt_d   = '0;
                  shift_d = '0;
               end
            end
            RECV: begin
               if (ws_chg) begin
                  cnt_d   = '0;
                  shift_d = '0;
                  if (cnt_q < CNT_W'(DATA_W - 1)) begin
                     short_d = 1'b1;
                  end else if (valid_q && !out_ready) begin
                     overrun_d = 1'b1;
                  end else begin
                     data_d  = word;
                     right_d = ws_prev_q;
                     valid_d = 1'b1;
                  end
               end else begin
                  shift_d = word;
                  if (cnt_q != CNT_W'(MAX_BITS)) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   assign out_data  = data_q;
   assign out_right = right_q;
   assign out_valid = valid_q;
   assign overrun   = overrun_q;
   assign short_err = short_q;

endmodule
